// File: rtl/bti_tcm.sv
// BTI slave TCM: single-port SRAM with byte strobes, errors flagged on misaligned/out-of-range access.
// Latency: response visible 2 cycles after accept (accept -> S1 register -> 3-entry response FIFO).
// Backpressure: req_rdy drops while 3 responses are outstanding; S1 never stalls because of that credit.
module bti_tcm #(
    parameter int              AW        = 32,
    parameter int              DW        = 32,
    parameter int              DEPTH     = 16384,
    parameter logic [AW-1:0]   BASE_ADDR = '0,
    parameter                  INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_vld,
    output logic              req_rdy,
    input  logic [AW-1:0]     req_addr,
    input  logic              req_wr,
    input  logic [DW-1:0]     req_wdata,
    input  logic [DW/8-1:0]   req_strb,
    output logic              rsp_vld,
    input  logic              rsp_rdy,
    output logic [DW-1:0]     rsp_rdata,
    output logic              rsp_err
);

    localparam int            SW        = DW / 8;
    localparam int            IW        = $clog2(DEPTH);
    localparam logic [AW:0]   MEM_BYTES = (AW+1)'(DEPTH) << 2;

    logic [DW-1:0] mem [DEPTH];

    logic          rst_done;
    logic [1:0]    outstanding;
    logic          accept;
    logic          pop;
    logic [AW-1:0] offs;
    logic          acc_err;
    logic [IW-1:0] idx;
    logic          wr_en;
    logic          rd_en;

    logic          s1_vld;
    logic          s1_err;
    logic [DW-1:0] s1_rdata;

    logic [DW:0]   fifo_mem [3];
    logic [1:0]    wr_ptr;
    logic [1:0]    rd_ptr;
    logic [1:0]    count;
    logic [DW:0]   head;

    function automatic logic [1:0] ptr_nxt(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // rst_done keeps req_rdy low until the first edge after reset release.
    assign req_rdy = rst_done && (outstanding != 2'd3);
    assign accept  = req_vld && req_rdy;
    assign pop     = rsp_vld && rsp_rdy;

    // Unsigned offset: addresses below BASE_ADDR wrap to large values and error.
    assign offs    = req_addr - BASE_ADDR;
    assign acc_err = (req_addr[1:0] != 2'b00) || ({1'b0, offs} >= MEM_BYTES);
    assign idx     = offs[IW+1:2];
    assign wr_en   = accept && req_wr && !acc_err;
    assign rd_en   = accept && !req_wr && !acc_err;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < SW; i++) begin
                if (req_strb[i]) begin
                    mem[idx][i*8 +: 8] <= req_wdata[i*8 +: 8];
                end
            end
        end
        s1_rdata <= rd_en ? mem[idx] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_done    <= 1'b0;
            outstanding <= 2'd0;
            s1_vld      <= 1'b0;
            s1_err      <= 1'b0;
            wr_ptr      <= 2'd0;
            rd_ptr      <= 2'd0;
            count       <= 2'd0;
        end else begin
            rst_done    <= 1'b1;
            outstanding <= outstanding + 2'(accept) - 2'(pop);
            s1_vld      <= accept;
            s1_err      <= accept && acc_err;
            count       <= count + 2'(s1_vld) - 2'(pop);
            if (s1_vld) begin
                wr_ptr <= ptr_nxt(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_nxt(rd_ptr);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (s1_vld) begin
            fifo_mem[wr_ptr] <= {s1_rdata, s1_err};
        end
    end

    // Gate the head so stale storage never leaks onto the bus when empty.
    assign head      = fifo_mem[rd_ptr];
    assign rsp_vld   = (count != 2'd0);
    assign rsp_rdata = rsp_vld ? head[DW:1] : '0;
    assign rsp_err   = rsp_vld && head[0];

endmodule

// File: tb/tb_bti_tcm.sv
// Directed bench for bti_tcm: vector table for single transactions, hand sequences for
// throughput, backpressure and mid-operation reset.
module tb_bti_tcm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_vld;
    logic        req_rdy;
    logic [31:0] req_addr;
    logic        req_wr;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic        rsp_vld;
    logic        rsp_rdy;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    always #5 clk = ~clk;

    bti_tcm dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_vld   (req_vld),
        .req_rdy   (req_rdy),
        .req_addr  (req_addr),
        .req_wr    (req_wr),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .rsp_vld   (rsp_vld),
        .rsp_rdy   (rsp_rdy),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } rsp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    rsp_t q[$];
    vec_t vecs[15];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rsp_vld && rsp_rdy) q.push_back('{rsp_rdata, rsp_err, cyc});
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb);
        req_vld   = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_strb  = strb;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int t0;
        q.delete();
        drive(v.wr, v.addr, v.wdata, v.strb);
        t0 = cyc;
        chk({nm, "_rdy"}, req_rdy, 1);
        step();
        req_vld = 1'b0;
        for (int w = 0; w < 10 && q.size() == 0; w++) step();
        chk({nm, "_count"}, q.size(), 1);
        if (q.size() != 0) begin
            chk({nm, "_rdata"}, q[0].rdata, v.exp_rdata);
            chk({nm, "_err"}, q[0].err, v.exp_err);
            chk({nm, "_lat"}, q[0].cyc - t0, 2);
        end
    endtask

    initial begin
        int   idx;
        logic acc;
        logic rdy_ok;

        vecs[0]  = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0100, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0100, 32'h1122_3344, 4'h5, 32'h0, 1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0100, 32'h0,         4'hF, 32'hDE22_BE44, 1'b0};
        vecs[4]  = '{1'b1, 32'h0000_0104, 32'h55AA_55AA, 4'hF, 32'h0, 1'b0};
        vecs[5]  = '{1'b1, 32'h0000_0104, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0};
        vecs[6]  = '{1'b0, 32'h0000_0104, 32'h0,         4'h0, 32'h55AA_55AA, 1'b0};
        vecs[7]  = '{1'b0, 32'h0000_0103, 32'h0,         4'h0, 32'h0, 1'b1};
        vecs[8]  = '{1'b0, 32'h0001_0000, 32'h0,         4'h0, 32'h0, 1'b1};
        vecs[9]  = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0};
        vecs[10] = '{1'b1, 32'h0001_0000, 32'h1234_5678, 4'hF, 32'h0, 1'b1};
        vecs[11] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0};
        vecs[12] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'h0, 1'b1};
        vecs[13] = '{1'b1, 32'h0000_FFFC, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0};
        vecs[14] = '{1'b0, 32'h0000_FFFC, 32'h0,         4'h0, 32'hA5A5_A5A5, 1'b0};

        rst_n = 1'b0; req_vld = 1'b0; req_wr = 1'b0; req_addr = '0;
        req_wdata = '0; req_strb = '0; rsp_rdy = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_rdy", req_rdy, 0);
        chk("rst_rsp_vld", rsp_vld, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        step();
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_req_rdy", req_rdy, 1);
        chk("post_rst_rsp_vld", rsp_vld, 0);
        step();

        for (int i = 0; i < 15; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back write/read pairs, each read hitting the word written the cycle before
        q.delete();
        rdy_ok = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k % 2 == 0) drive(1'b1, 32'h200 + 32'(4 * (k / 2)), 32'h1000_0000 + 32'(k / 2), 4'hF);
            else            drive(1'b0, 32'h200 + 32'(4 * (k / 2)), 32'h0, 4'h0);
            if (!req_rdy) rdy_ok = 1'b0;
            step();
        end
        req_vld = 1'b0;
        for (int w = 0; w < 20 && q.size() < 16; w++) step();
        chk("tput_rdy_held", rdy_ok, 1);
        chk("tput_count", q.size(), 16);
        if (q.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                chk($sformatf("tput_rdata%0d", i), q[i].rdata,
                    (i % 2 == 0) ? 32'h0 : 32'h1000_0000 + 32'(i / 2));
                chk($sformatf("tput_cyc%0d", i), q[i].cyc - q[0].cyc, i);
            end
        end

        // Backpressure: rsp_rdy low, 5 reads offered
        rsp_rdy = 1'b0;
        q.delete();
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            if (idx < 5) drive(1'b0, 32'h200 + 32'(4 * idx), 32'h0, 4'h0);
            else         req_vld = 1'b0;
            acc = req_vld && req_rdy;
            step();
            if (acc) idx++;
        end
        chk("bp_accepted", idx, 3);
        chk("bp_req_rdy", req_rdy, 0);
        chk("bp_rsp_vld", rsp_vld, 1);
        chk("bp_head", rsp_rdata, 32'h1000_0000);
        repeat (2) step();
        chk("bp_head_stable", rsp_rdata, 32'h1000_0000);
        chk("bp_vld_stable", rsp_vld, 1);
        chk("bp_no_pop", q.size(), 0);
        rsp_rdy = 1'b1;
        for (int c = 0; c < 20 && idx < 5; c++) begin
            drive(1'b0, 32'h200 + 32'(4 * idx), 32'h0, 4'h0);
            acc = req_rdy;
            step();
            if (acc) idx++;
        end
        req_vld = 1'b0;
        for (int w = 0; w < 20 && q.size() < 5; w++) step();
        chk("bp_total", q.size(), 5);
        if (q.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("bp_rdata%0d", i), q[i].rdata, 32'h1000_0000 + 32'(i));
                chk($sformatf("bp_err%0d", i), q[i].err, 0);
            end
        end

        // Reset with two responses pending
        rsp_rdy = 1'b0;
        drive(1'b1, 32'h300, 32'h7777_7777, 4'hF);
        step();
        drive(1'b0, 32'h100, 32'h0, 4'h0);
        step();
        req_vld = 1'b0;
        repeat (2) step();
        chk("mid_pending_vld", rsp_vld, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", rsp_vld, 0);
        chk("mid_rst_rdata", rsp_rdata, 0);
        chk("mid_rst_rdy", req_rdy, 0);
        step();
        rst_n = 1'b1;
        q.delete();
        rsp_rdy = 1'b1;
        repeat (3) step();
        chk("mid_dropped", q.size(), 0);
        run_vec('{1'b0, 32'h0000_0300, 32'h0, 4'h0, 32'h7777_7777, 1'b0}, "mid_keep300");
        run_vec('{1'b0, 32'h0000_0100, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0}, "mid_keep100");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
